// File: rtl/result_pkg.sv
// Shared widths and types for the result packer: nibble and packed-word types,
// plus the FIFO level-width helper.
package result_pkg;

   localparam int NIB_W   = 4;
   localparam int NIBBLES = 4;
   localparam int WORD_W  = NIB_W * NIBBLES;

   typedef logic [NIB_W-1:0]  nib_t;
   typedef logic [WORD_W-1:0] word_t;

   // Bits needed to count 0..depth inclusive.
   function automatic int lvl_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/word_fifo.sv
// Small word FIFO with wrap-bit pointers. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise the push is ignored.
module word_fifo
   import result_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = lvl_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WORD_W-1:0] wr_data,
   output logic [WORD_W-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;
   word_t            mem_q [DEPTH];

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      // Same index with differing wrap bits means the writer has lapped the reader.
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);

      if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);

      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
      level   = level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage is deliberately not reset; rd_data is gated by empty, so stale
   // or uninitialised entries never reach the output.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/result_packer.sv
// Packs strobed result nibbles LSB-first into words, queues completed words
// in a FIFO and raises a sticky overflow flag when a word has to be dropped.
module result_packer
   import result_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = lvl_width(DEPTH)
) (
   input  logic              fast_clk,
   input  logic              rst_n,
   input  logic [NIB_W-1:0]  in_nib,
   input  logic              in_strobe,
   input  logic              flush,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam int IDX_W = $clog2(NIBBLES);

   logic [IDX_W-1:0] idx_q, idx_d;
   word_t            partial_q, partial_d;
   logic             ovf_q, ovf_d;

   word_t            packed_word;
   logic             word_done;
   logic             pop_fire;
   logic             drop;
   logic             fifo_full, fifo_empty;

   always_comb begin
      idx_d     = idx_q;
      partial_d = partial_q;
      ovf_d     = ovf_q;
      word_done = 1'b0;

      packed_word = partial_q;
      packed_word[idx_q*NIB_W +: NIB_W] = in_nib;

      // Flush outranks a same-cycle strobe: that nibble is discarded.
      if (flush) begin
         idx_d     = '0;
         partial_d = '0;
      end else if (in_strobe) begin
         if (idx_q == IDX_W'(NIBBLES-1)) begin
            word_done = 1'b1;
            idx_d     = '0;
            partial_d = '0;
         end else begin
            idx_d     = idx_q + IDX_W'(1);
            partial_d = packed_word;
         end
      end

      pop_fire = ~fifo_empty & out_ready;
      drop     = word_done & fifo_full & ~pop_fire;

      // A drop in the same cycle as a clear keeps the flag set.
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         partial_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         partial_q <= partial_d;
         ovf_q     <= ovf_d;
      end
   end

   word_fifo #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk     (fast_clk),
      .rst_n   (rst_n),
      .push    (word_done),
      .pop     (pop_fire),
      .wr_data (packed_word),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign out_valid = ~fifo_empty;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_result_packer;
   import result_pkg::*;

   localparam int DEPTH = 4;
   localparam int LVL_W = lvl_width(DEPTH);

   logic              fast_clk;
   logic              rst_n;
   logic [NIB_W-1:0]  in_nib;
   logic              in_strobe;
   logic              flush;
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic              overflow;
   logic              clr_ovf;

   int checks = 0;
   int errors = 0;

   // Reference model: collected nibbles, queued words, sticky flag.
   logic [NIB_W-1:0]  m_nibs [$];
   logic [WORD_W-1:0] m_fifo [$];
   bit                m_ovf;

   result_packer #(.DEPTH(DEPTH)) dut (
      .fast_clk  (fast_clk),
      .rst_n     (rst_n),
      .in_nib    (in_nib),
      .in_strobe (in_strobe),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial fast_clk = 1'b0;
   always #5 fast_clk = ~fast_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_nibs.delete();
      m_fifo.delete();
      m_ovf = 0;
   endtask

   // Applies one clock edge's worth of behaviour using the currently driven inputs.
   task automatic model_step();
      bit                done;
      bit                pop;
      logic [WORD_W-1:0] w;
      done = 0;
      w    = '0;
      pop  = (m_fifo.size() > 0) && out_ready;
      if (flush) begin
         m_nibs.delete();
      end else if (in_strobe) begin
         m_nibs.push_back(in_nib);
         if (m_nibs.size() == NIBBLES) begin
            for (int i = 0; i < NIBBLES; i++)
               w = w | (WORD_W'(m_nibs[i]) << (NIB_W * i));
            m_nibs.delete();
            done = 1;
         end
      end
      if (pop) void'(m_fifo.pop_front());
      if (clr_ovf) m_ovf = 0;
      if (done) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
         else m_ovf = 1;
      end
   endtask

   task automatic compare_model();
      check("valid", 32'(out_valid), 32'(m_fifo.size() > 0));
      check("level", 32'(level), 32'(m_fifo.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_fifo.size() > 0) check("data", 32'(out_data), 32'(m_fifo[0]));
   endtask

   task automatic tick();
      model_step();
      @(posedge fast_clk);
      #1;
      compare_model();
   endtask

   task automatic cyc(input bit stb, input logic [NIB_W-1:0] nib, input bit fl,
                      input bit rdy, input bit clr);
      in_strobe = stb;
      in_nib    = nib;
      flush     = fl;
      out_ready = rdy;
      clr_ovf   = clr;
      tick();
   endtask

   task automatic feed_word(input logic [WORD_W-1:0] w, input bit rdy);
      for (int i = 0; i < NIBBLES; i++) cyc(1, w[NIB_W*i +: NIB_W], 0, rdy, 0);
   endtask

   initial begin
      logic [WORD_W-1:0] exp2 [4];
      logic [WORD_W-1:0] exp3 [4];
      exp2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      exp3 = '{16'h1002, 16'h1003, 16'h1004, 16'h6666};

      rst_n = 0; in_nib = '0; in_strobe = 0; flush = 0; out_ready = 0; clr_ovf = 0;
      model_reset();
      repeat (2) @(posedge fast_clk);
      @(negedge fast_clk);
      rst_n = 1;
      @(posedge fast_clk);
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_level", 32'(level), 0);
      check("rst_ovf", 32'(overflow), 0);

      // 1: four separate strobes, word visible for exactly one cycle.
      for (int i = 1; i <= 4; i++) begin
         cyc(1, NIB_W'(i), 0, 1, 0);
         if (i < 4) begin
            check("t1_not_yet", 32'(out_valid), 0);
            cyc(0, 0, 0, 1, 0);
         end
      end
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'h4321);
      cyc(0, 0, 0, 1, 0);
      check("t1_gone", 32'(out_valid), 0);
      check("t1_level", 32'(level), 0);

      // 2: five words into a stalled FIFO; the fifth is dropped.
      feed_word(16'h1111, 0);
      feed_word(16'h2222, 0);
      feed_word(16'h3333, 0);
      feed_word(16'h4444, 0);
      feed_word(16'h5555, 0);
      check("t2_level", 32'(level), 4);
      check("t2_ovf", 32'(overflow), 1);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("t2_pop_data", 32'(out_data), 32'(exp2[i]));
         cyc(0, 0, 0, 1, 0);
      end
      check("t2_drained", 32'(out_valid), 0);

      // 3: completion on the same edge as a pop from a full FIFO.
      cyc(0, 0, 0, 0, 1);
      check("t3_ovf_clr", 32'(overflow), 0);
      feed_word(16'h1001, 0);
      feed_word(16'h1002, 0);
      feed_word(16'h1003, 0);
      feed_word(16'h1004, 0);
      for (int i = 0; i < NIBBLES-1; i++) cyc(1, 4'h6, 0, 0, 0);
      check("t3_full", 32'(level), 4);
      cyc(1, 4'h6, 0, 1, 0);
      check("t3_level", 32'(level), 4);
      check("t3_ovf", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         check("t3_order", 32'(out_data), 32'(exp3[i]));
         cyc(0, 0, 0, 1, 0);
      end
      check("t3_drained", 32'(out_valid), 0);

      // 4: flush discards A, B and the concurrent C.
      cyc(1, 4'hA, 0, 0, 0);
      cyc(1, 4'hB, 0, 0, 0);
      cyc(1, 4'hC, 1, 0, 0);
      check("t4_no_word", 32'(out_valid), 0);
      feed_word(16'h4321, 0);
      check("t4_level", 32'(level), 1);
      check("t4_data", 32'(out_data), 32'h4321);
      cyc(0, 0, 0, 1, 0);
      check("t4_drained", 32'(out_valid), 0);

      // 5: asynchronous reset mid-word with a word queued and the flag set.
      feed_word(16'h9999, 0);
      feed_word(16'h9998, 0);
      feed_word(16'h9997, 0);
      feed_word(16'h9996, 0);
      feed_word(16'h9995, 0);
      for (int i = 0; i < 3; i++) cyc(1, 4'h3, 0, 0, 0);
      in_strobe = 0; in_nib = '0;
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check("t5_valid", 32'(out_valid), 0);
      check("t5_level", 32'(level), 0);
      check("t5_ovf", 32'(overflow), 0);
      check("t5_data", 32'(out_data), 0);
      #1;
      rst_n = 1;
      feed_word(16'h8765, 0);
      check("t5_data_after", 32'(out_data), 32'h8765);
      check("t5_level_after", 32'(level), 1);
      cyc(0, 0, 0, 1, 0);

      // 6: clear alone, then clear coinciding with a fresh drop.
      for (int i = 0; i < 5; i++) feed_word(16'h0F00 + WORD_W'(i), 0);
      check("t6_ovf_set", 32'(overflow), 1);
      cyc(0, 0, 0, 0, 1);
      check("t6_ovf_cleared", 32'(overflow), 0);
      for (int i = 0; i < NIBBLES-1; i++) cyc(1, 4'h7, 0, 0, 0);
      cyc(1, 4'h7, 0, 0, 1);
      check("t6_drop_wins", 32'(overflow), 1);
      check("t6_level", 32'(level), 4);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         cyc(bit'($urandom_range(0, 1)),
             NIB_W'($urandom),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 11) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Downstream consumer of the slow-domain multiplier datapath, clocked entirely on fast_clk.
- Samples each 4-bit result on a one-cycle strobe. The strobe is the phase-aligned enable pulse that marks a new slow-domain result.
- Packs NIBBLES consecutive results LSB-first into one word and queues completed words in a small FIFO.
- Presents queued words on a valid/ready output interface, with a sticky overflow flag.

Parameters:
- NIB_W, 4, width of each incoming result.
- NIBBLES, 4, results per packed word; must be ≥2.
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- Derived: WORD_W = NIB_W*NIBBLES (16); LVL_W = clog2(DEPTH+1) (3).

Ports:
- fast_clk  in  1  sole clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_nib  in  NIB_W  result nibble, sampled only when in_strobe=1.
- in_strobe  in  1  one-cycle qualifier for in_nib.
- flush  in  1  discards the partially packed word.
- out_data  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid & out_ready.
- level  out  LVL_W  words currently in the FIFO (0..DEPTH).
- overflow  out  1  sticky: a completed word was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, level=0, overflow=0.
  - pack index=0, partial word=0, FIFO pointers=0.
  - Takes effect immediately, including mid-word and mid-transfer; no partial word survives.
- Packing:
  - A nibble sampled on strobe at pack index k occupies bits [k*NIB_W +: NIB_W].
  - Index increments on each strobe and wraps from NIBBLES-1 to 0.
- Word completion:
  - A strobe at index NIBBLES-1 forms {in_nib, partial[lower bits]} combinationally.
  - That word is pushed into the FIFO at the same edge; the partial register clears to 0.
- Latency:
  - Final strobe sampled at edge N → out_valid=1 and out_data valid after edge N (visible in cycle N+1), provided the FIFO was empty.
  - One cycle from final nibble to output.
- Pop:
  - Occurs on an edge where out_valid=1 and out_ready=1.
  - The next entry appears after that edge; out_valid drops if the FIFO becomes empty.
- out_data rules:
  - out_data holds steady while out_valid=1 and out_ready=0.
  - out_data is don't-care when out_valid=0 but must not be X after reset.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - This applies when full: a push into a full FIFO with a simultaneous pop is accepted, not an overflow.
  - When empty, a pop is impossible because out_valid=0.
- Full:
  - A push with level=DEPTH and no pop drops the completed word and sets overflow.
  - The FIFO contents are unaltered.
  - The pack index still wraps to 0 and the partial register clears.
- Flush:
  - Pack index goes to 0 and the partial register goes to 0 at the next edge.
  - Flush has priority: a strobe in the same cycle is discarded.
  - FIFO contents, level and overflow are unaffected.
- Overflow flag:
  - clr_ovf clears overflow at the next edge.
  - If a drop occurs in the same cycle as clr_ovf, the drop wins and overflow stays 1.
- level:
  - Registered; equals pushes minus pops since reset.
  - Must never exceed DEPTH or underflow.
- Pointers: FIFO pointers are clog2(DEPTH) bits with an extra wrap bit, so full and empty are distinguished without using level.

Decomposition:
- Package result_pkg holds:
  - localparams NIB_W, NIBBLES, WORD_W.
  - typedef logic [NIB_W-1:0] nib_t.
  - typedef logic [WORD_W-1:0] word_t.
  - The helper function lvl_width(depth).
- One sub-module: word_fifo (DEPTH, word_t; push/pop/full/empty/level).
- Packing, flush and overflow logic stay in result_packer.

Test Plan:
1. Reset, then strobe nibbles 1,2,3,4 on four separate strobes with out_ready=1 → out_data=16'h4321 with out_valid=1 for exactly one cycle, appearing the cycle after the 4th strobe; level returns to 0.
2. Hold out_ready=0 and feed 5 words (0x1111,0x2222,0x3333,0x4444,0x5555) → level=4 and overflow=1 after the 5th word. Then raise out_ready → pops 0x1111,0x2222,0x3333,0x4444 in order; 0x5555 never appears.
3. FIFO full (level=4) with out_ready=1 held and a 5th word completing on the same edge as a pop → level stays 4, overflow stays 0, and the new word appears last in the output sequence.
4. Strobe A,B, then assert flush with a concurrent strobe of C, then strobe 1,2,3,4 → the only word out is 16'h4321; A, B and C are never seen.
5. Strobe 3 nibbles, assert rst_n=0 mid-cycle (asynchronously) → out_valid, level and overflow go to 0 immediately. After release, nibbles 5,6,7,8 → out_data=16'h8765.
6. Cause an overflow, then assert clr_ovf alone → overflow=0 the next cycle. Repeat with clr_ovf coinciding with a new drop → overflow remains 1.
